rsa_job_sequencer: RTL and testbench

Sequences one RSA `control` datapath instance on behalf of a single requester.
- Accepts a job (p, q, encrypt_decrypt, message) over a valid/ready handshake.
- Drives the datapath's reset_inverter / reset_mod_exp pulses and waits for inverter_finish / mod_exp_finish.
- Returns the result over a valid/ready response handshake.
- Caches the last key, so back-to-back jobs with an unchanged key skip the inverter phase.

---
 rtl/rsa_job_sequencer.sv | 276 +++++++++++++++++++++++++++
 tb/tb_rsa_job_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_job_sequencer.sv
// -----------------------------------------------------------------------------
// rsa_job_sequencer
//
// Runs one RSA "control" datapath on behalf of a single requester. A job
// (p, q, encrypt_decrypt, message) arrives on a valid/ready handshake. The
// sequencer pulses the datapath's inverter and mod-exp resets, waits for each
// finish flag, and returns the result on a valid/ready response handshake.
// The last key is cached. A back-to-back job with an unchanged key skips the
// inverter phase.
//
// Optional feature macro: RSA_SEQ_TIMEOUT_EN
//   Defined   : each wait phase has a watchdog of TIMEOUT_CYCLES cycles. On
//               expiry the job ends with rsp_error=1, rsp_msg=0, and the key
//               cache is invalidated.
//   Undefined : waits are unbounded and rsp_error is tied to 0.
//
// Ports
//   clk, reset              rising-edge clock, async active-high reset
//   req_valid/req_ready     job request handshake
//   req_p, req_q            primes (WIDTH bits)
//   req_encrypt_decrypt     0=encrypt, 1=decrypt
//   req_msg                 input message (2*WIDTH bits)
//   rsp_valid/rsp_ready     result handshake
//   rsp_msg, rsp_error      result message, watchdog abort flag
//   busy                    high whenever not idle
//   ctl_*                   datapath operands, start pulses and finish/result
// -----------------------------------------------------------------------------
module rsa_job_sequencer #(
    parameter int WIDTH          = 128,
    parameter int PULSE_LEN      = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_p,
    input  logic [WIDTH-1:0]     req_q,
    input  logic                 req_encrypt_decrypt,
    input  logic [2*WIDTH-1:0]   req_msg,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_msg,
    output logic                 rsp_error,
    output logic                 busy,
    output logic [WIDTH-1:0]     ctl_p,
    output logic [WIDTH-1:0]     ctl_q,
    output logic                 ctl_encrypt_decrypt,
    output logic [2*WIDTH-1:0]   ctl_msg_in,
    output logic                 ctl_reset_inverter,
    output logic                 ctl_reset_mod_exp,
    input  logic                 ctl_inverter_finish,
    input  logic                 ctl_mod_exp_finish,
    input  logic [2*WIDTH-1:0]   ctl_msg_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INV_PULSE,
        S_INV_WAIT,
        S_EXP_PULSE,
        S_EXP_WAIT,
        S_RESP
    } state_t;

    localparam int PCW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_LEN - 1);

    state_t               state_q, state_d;
    logic                 key_valid_q, key_valid_d;
    logic [WIDTH-1:0]     key_p_q, key_p_d;
    logic [WIDTH-1:0]     key_q_q, key_q_d;
    logic                 key_ed_q, key_ed_d;
    logic [WIDTH-1:0]     ctl_p_q, ctl_p_d;
    logic [WIDTH-1:0]     ctl_q_q, ctl_q_d;
    logic                 ctl_ed_q, ctl_ed_d;
    logic [2*WIDTH-1:0]   ctl_msg_q, ctl_msg_d;
    logic [PCW-1:0]       pulse_cnt_q, pulse_cnt_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [2*WIDTH-1:0]   rsp_msg_q, rsp_msg_d;

`ifdef RSA_SEQ_TIMEOUT_EN
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);

    logic [TCW-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                 rsp_error_q, rsp_error_d;
`else
    // Keeps the watchdog parameter referenced when the feature is compiled out.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    logic accept;
    logic key_hit;

    assign accept  = req_valid && (state_q == S_IDLE);
    assign key_hit = key_valid_q && (req_p == key_p_q) && (req_q == key_q_q)
                     && (req_encrypt_decrypt == key_ed_q);

    always_comb begin
        state_d     = state_q;
        key_valid_d = key_valid_q;
        key_p_d     = key_p_q;
        key_q_d     = key_q_q;
        key_ed_d    = key_ed_q;
        ctl_p_d     = ctl_p_q;
        ctl_q_d     = ctl_q_q;
        ctl_ed_d    = ctl_ed_q;
        ctl_msg_d   = ctl_msg_q;
        pulse_cnt_d = pulse_cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_msg_d   = rsp_msg_q;
`ifdef RSA_SEQ_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        rsp_error_d = rsp_error_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ctl_p_d     = req_p;
                    ctl_q_d     = req_q;
                    ctl_ed_d    = req_encrypt_decrypt;
                    ctl_msg_d   = req_msg;
                    pulse_cnt_d = '0;
                    if (key_hit) begin
                        state_d = S_EXP_PULSE;
                    end else begin
                        // Invalidate until the inverter confirms the new key.
                        key_p_d     = req_p;
                        key_q_d     = req_q;
                        key_ed_d    = req_encrypt_decrypt;
                        key_valid_d = 1'b0;
                        state_d     = S_INV_PULSE;
                    end
                end
            end

            // The finish flag may still be high from the previous job here,
            // so it is deliberately not looked at until INV_WAIT.
            S_INV_PULSE: begin
                if (pulse_cnt_q == PULSE_LAST) begin
                    pulse_cnt_d = '0;
                    state_d     = S_INV_WAIT;
`ifdef RSA_SEQ_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end else begin
                    pulse_cnt_d = pulse_cnt_q + 1'b1;
                end
            end

            S_INV_WAIT: begin
                if (ctl_inverter_finish) begin
                    key_valid_d = 1'b1;
                    pulse_cnt_d = '0;
                    state_d     = S_EXP_PULSE;
                end
`ifdef RSA_SEQ_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    key_valid_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_msg_d   = '0;
                    rsp_error_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end

            S_EXP_PULSE: begin
                if (pulse_cnt_q == PULSE_LAST) begin
                    pulse_cnt_d = '0;
                    state_d     = S_EXP_WAIT;
`ifdef RSA_SEQ_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end else begin
                    pulse_cnt_d = pulse_cnt_q + 1'b1;
                end
            end

            S_EXP_WAIT: begin
                if (ctl_mod_exp_finish) begin
                    rsp_valid_d = 1'b1;
                    rsp_msg_d   = ctl_msg_out;
`ifdef RSA_SEQ_TIMEOUT_EN
                    rsp_error_d = 1'b0;
`endif
                    state_d     = S_RESP;
                end
`ifdef RSA_SEQ_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    key_valid_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_msg_d   = '0;
                    rsp_error_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end

            // Returning to IDLE only after the handshake means req_ready rises
            // one cycle later, so no job is accepted in the handshake cycle.
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            key_valid_q <= 1'b0;
            key_p_q     <= '0;
            key_q_q     <= '0;
            key_ed_q    <= 1'b0;
            ctl_p_q     <= '0;
            ctl_q_q     <= '0;
            ctl_ed_q    <= 1'b0;
            ctl_msg_q   <= '0;
            pulse_cnt_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_msg_q   <= '0;
`ifdef RSA_SEQ_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            rsp_error_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            key_valid_q <= key_valid_d;
            key_p_q     <= key_p_d;
            key_q_q     <= key_q_d;
            key_ed_q    <= key_ed_d;
            ctl_p_q     <= ctl_p_d;
            ctl_q_q     <= ctl_q_d;
            ctl_ed_q    <= ctl_ed_d;
            ctl_msg_q   <= ctl_msg_d;
            pulse_cnt_q <= pulse_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_msg_q   <= rsp_msg_d;
`ifdef RSA_SEQ_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            rsp_error_q <= rsp_error_d;
`endif
        end
    end

    assign req_ready           = (state_q == S_IDLE);
    assign busy                = (state_q != S_IDLE);
    assign ctl_reset_inverter  = (state_q == S_INV_PULSE);
    assign ctl_reset_mod_exp   = (state_q == S_EXP_PULSE);
    assign ctl_p               = ctl_p_q;
    assign ctl_q               = ctl_q_q;
    assign ctl_encrypt_decrypt = ctl_ed_q;
    assign ctl_msg_in          = ctl_msg_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_msg             = rsp_msg_q;
`ifdef RSA_SEQ_TIMEOUT_EN
    assign rsp_error           = rsp_error_q;
`else
    assign rsp_error           = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rsa_job_sequencer
//
// Drives rsa_job_sequencer against a small datapath stand-in. The stand-in
// finishes after a programmable delay, and its result is msg ^ {p, q} of the
// key it last inverted, so encrypt followed by decrypt returns the original
// message. A key-cache model predicts hit/miss, pulse counts, latency and
// result for each job.
// -----------------------------------------------------------------------------
module tb_rsa_job_sequencer;

    localparam int W   = 128;
    localparam int PL  = 2;
    localparam int TMO = 100;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [W-1:0]     req_p, req_q;
    logic             req_encrypt_decrypt;
    logic [2*W-1:0]   req_msg;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [2*W-1:0]   rsp_msg;
    logic             rsp_error;
    logic             busy;
    logic [W-1:0]     ctl_p, ctl_q;
    logic             ctl_encrypt_decrypt;
    logic [2*W-1:0]   ctl_msg_in;
    logic             ctl_reset_inverter, ctl_reset_mod_exp;
    logic             inv_fin = 1'b0, exp_fin = 1'b0;
    logic [2*W-1:0]   dp_out = '0;

    always #5 clk = ~clk;

    rsa_job_sequencer #(.WIDTH(W), .PULSE_LEN(PL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_p(req_p), .req_q(req_q), .req_encrypt_decrypt(req_encrypt_decrypt),
        .req_msg(req_msg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_msg(rsp_msg),
        .rsp_error(rsp_error), .busy(busy),
        .ctl_p(ctl_p), .ctl_q(ctl_q), .ctl_encrypt_decrypt(ctl_encrypt_decrypt),
        .ctl_msg_in(ctl_msg_in),
        .ctl_reset_inverter(ctl_reset_inverter), .ctl_reset_mod_exp(ctl_reset_mod_exp),
        .ctl_inverter_finish(inv_fin), .ctl_mod_exp_finish(exp_fin),
        .ctl_msg_out(dp_out)
    );

    // Datapath stand-in: finish flags stay high until the next start pulse.
    int             inv_dly = 0, exp_dly = 0;
    logic           exp_hang = 1'b0;
    logic           inv_busy = 1'b0, exp_busy = 1'b0;
    int             inv_cnt = 0, exp_cnt = 0;
    logic [2*W-1:0] dp_key = '0;

    always @(posedge clk) begin
        if (ctl_reset_inverter) begin
            inv_fin <= 1'b0; inv_busy <= 1'b1; inv_cnt <= inv_dly;
        end else if (inv_busy) begin
            if (inv_cnt == 0) begin
                inv_fin <= 1'b1; inv_busy <= 1'b0; dp_key <= {ctl_p, ctl_q};
            end else inv_cnt <= inv_cnt - 1;
        end
        if (ctl_reset_mod_exp) begin
            exp_fin <= 1'b0; exp_busy <= 1'b1; exp_cnt <= exp_dly;
        end else if (exp_busy && !exp_hang) begin
            if (exp_cnt == 0) begin
                exp_fin <= 1'b1; exp_busy <= 1'b0; dp_out <= ctl_msg_in ^ dp_key;
            end else exp_cnt <= exp_cnt - 1;
        end
    end

    // Pulse monitor: cumulative high-cycle and rising-edge counts.
    int   inv_hi = 0, inv_rise = 0, exp_hi = 0, exp_rise = 0;
    logic inv_prev = 1'b0, exp_prev = 1'b0;

    always @(posedge clk) begin
        inv_prev <= ctl_reset_inverter;
        exp_prev <= ctl_reset_mod_exp;
        if (ctl_reset_inverter) inv_hi <= inv_hi + 1;
        if (ctl_reset_inverter && !inv_prev) inv_rise <= inv_rise + 1;
        if (ctl_reset_mod_exp) exp_hi <= exp_hi + 1;
        if (ctl_reset_mod_exp && !exp_prev) exp_rise <= exp_rise + 1;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Key-cache reference model.
    logic         mdl_kv = 1'b0;
    logic [W-1:0] mdl_p = '0, mdl_q = '0;
    logic         mdl_ed = 1'b0;

    // bp < 0: rsp_ready high in advance; bp >= 0: rsp_ready low for bp cycles.
    task automatic run_job(input logic [W-1:0] p, input logic [W-1:0] q, input logic ed,
                           input logic [2*W-1:0] msg, input int bp,
                           output logic [2*W-1:0] res);
        int   i0h, i0r, e0h, e0r, lat, exp_lat;
        logic hit;
        hit = mdl_kv && (p == mdl_p) && (q == mdl_q) && (ed == mdl_ed);
        if (!hit) begin
            mdl_p = p; mdl_q = q; mdl_ed = ed; mdl_kv = 1'b0;
        end
        inv_dly = $urandom_range(0, 4);
        exp_dly = $urandom_range(0, 4);
        chk("req_ready_idle", req_ready, 1);
        i0h = inv_hi; i0r = inv_rise; e0h = exp_hi; e0r = exp_rise;
        req_p = p; req_q = q; req_encrypt_decrypt = ed; req_msg = msg; req_valid = 1'b1;
        if (bp < 0) rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        chk("ctl_p", ctl_p, p);
        chk("ctl_q", ctl_q, q);
        chk("ctl_ed", ctl_encrypt_decrypt, ed);
        chk("ctl_msg_in", ctl_msg_in, msg);
        if (hit) chk("exp_pulse_first_cycle", ctl_reset_mod_exp, 1);
        else     chk("inv_pulse_first_cycle", ctl_reset_inverter, 1);
        lat = 1;
        while (!rsp_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        exp_lat = hit ? (PL + 3 + exp_dly) : (2 * PL + 5 + inv_dly + exp_dly);
        chk("rsp_latency", lat, exp_lat);
        chk("rsp_msg", rsp_msg, msg ^ {p, q});
        chk("rsp_error", rsp_error, 0);
        chk("inv_pulse_count", inv_rise - i0r, hit ? 0 : 1);
        chk("inv_pulse_cycles", inv_hi - i0h, hit ? 0 : PL);
        chk("exp_pulse_count", exp_rise - e0r, 1);
        chk("exp_pulse_cycles", exp_hi - e0h, PL);
        mdl_kv = 1'b1;
        res = msg ^ {p, q};
        if (bp > 0) begin
            // A competing request during backpressure must not be taken.
            req_p = ~p; req_msg = ~msg; req_valid = 1'b1;
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                chk("bp_rsp_valid", rsp_valid, 1);
                chk("bp_rsp_msg_stable", rsp_msg, res);
                chk("bp_req_ready_low", req_ready, 0);
                chk("bp_ctl_msg_held", ctl_msg_in, msg);
            end
        end
        if (bp >= 0) rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_dropped", rsp_valid, 0);
        chk("req_ready_after_hs", req_ready, 1);
        chk("ctl_msg_not_reaccepted", ctl_msg_in, msg);
        req_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0]   kp [3];
        logic [W-1:0]   kq [3];
        logic [2*W-1:0] r1, r2, r3, r4, rr;
        logic [W-1:0]   p1, q1;
        int             k;

        p1 = 128'd113680897410347;
        q1 = 128'd7999808077935876437321;
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_p = '0; req_q = '0; req_encrypt_decrypt = 1'b0; req_msg = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_msg", rsp_msg, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_ctl_p", ctl_p, 0);
        chk("rst_ctl_msg_in", ctl_msg_in, 0);
        chk("rst_pulses", {ctl_reset_inverter, ctl_reset_mod_exp}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Cold miss, back-to-back hit, round trip, backpressure on a hit.
        run_job(p1, q1, 1'b0, 256'h7b2857e70000, 0, r1);
        run_job(p1, q1, 1'b0, 256'hf03ab37b2857e7e149, -1, r2);
        run_job(p1, q1, 1'b1, r1, 0, r3);
        chk("round_trip_msg", r3, 256'h7b2857e70000);
        run_job(p1, q1, 1'b1, 256'h1234_5678_9abc, 20, r4);

        // Reset while waiting for the inverter.
        mdl_p = p1 + 1; mdl_q = q1; mdl_ed = 1'b0; mdl_kv = 1'b0;
        inv_dly = 20;
        req_p = p1 + 1; req_q = q1; req_encrypt_decrypt = 1'b0; req_msg = 256'h55;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (PL) @(negedge clk);
        chk("midjob_busy", busy, 1);
        chk("midjob_inv_pulse_low", ctl_reset_inverter, 0);
        reset = 1'b1;
        #1;
        chk("async_rst_req_ready", req_ready, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ctl_p", ctl_p, 0);
        chk("async_rst_ctl_msg", ctl_msg_in, 0);
        chk("async_rst_rsp_valid", rsp_valid, 0);
        mdl_kv = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_job(p1 + 1, q1, 1'b0, 256'h55, 0, rr);

        // Random jobs over a small key pool so hits and misses both occur.
        for (int i = 0; i < 3; i++) begin
            kp[i] = {$urandom, $urandom, $urandom, $urandom};
            kq[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        for (int j = 0; j < 24; j++) begin
            k = $urandom_range(0, 2);
            run_job(kp[k], kq[k], 1'($urandom_range(0, 1)),
                    {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                    $urandom_range(0, 4) - 1, rr);
        end

`ifdef RSA_SEQ_TIMEOUT_EN
        // Watchdog: the datapath never finishes mod-exp.
        exp_hang = 1'b1;
        req_p = mdl_p; req_q = mdl_q; req_encrypt_decrypt = mdl_ed; req_msg = 256'h99;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_rsp_valid", rsp_valid, 1);
        chk("tmo_rsp_error", rsp_error, 1);
        chk("tmo_rsp_msg", rsp_msg, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_hang = 1'b0;
        mdl_kv = 1'b0;
        run_job(mdl_p, mdl_q, mdl_ed, 256'h77, 0, rr);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
